// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data memory between the CPU load/store
// path (port 0) and the debug/program-loader port (port 1). Every access runs
// IDLE -> ACCESS -> RESP. Ties favour the CPU, but after CPU_WEIGHT
// consecutive CPU grants with debug pending, debug is forced through.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until its ack. ack is a one-cycle pulse and rdata is valid while ack is
// high. The request is sampled only in IDLE, so a req still high after ack
// counts as a new request. A req that drops before it is granted is never
// served.
module dm_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int CPU_WEIGHT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WEIGHT = 4'(CPU_WEIGHT);

  state_t            state;
  logic              owner;      // 0 = CPU, 1 = debug
  logic [3:0]        streak;     // CPU grants won while debug was waiting
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_dbg;

  // Winner selection in IDLE: debug wins when alone, or when the CPU has
  // used up its weight of consecutive contested grants.
  always_comb begin
    grant_dbg = dbg_req & (~cpu_req | (streak >= WEIGHT));
  end

  // Access sequencer: arbitrate in IDLE, one memory cycle, one ack cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      streak    <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            state <= ACCESS;
            owner <= grant_dbg;
            if (grant_dbg) begin
              lat_we    <= dbg_we;
              lat_addr  <= dbg_addr;
              lat_wdata <= dbg_wdata;
              streak    <= 4'd0;
            end else begin
              lat_we    <= cpu_we;
              lat_addr  <= cpu_addr;
              lat_wdata <= cpu_wdata;
              if (!dbg_req) begin
                streak <= 4'd0;
              end else if (streak != 4'hF) begin
                streak <= streak + 4'd1;
              end
            end
          end
        end
        ACCESS: begin
          state <= RESP;
          // Only the owner's read register captures; writes leave both alone.
          if (!lat_we) begin
            if (owner) begin
              dbg_rdata <= dm_dout;
            end else begin
              cpu_rdata <= dm_dout;
            end
          end
          cpu_ack <= ~owner;
          dbg_ack <= owner;
        end
        RESP: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
        end
      endcase
    end
  end

  // Memory drive: the write strobe is gated by ACCESS so an asynchronous
  // reset (which forces IDLE) kills it at once; address/data simply hold.
  always_comb begin
    dm_addr = lat_addr;
    dm_din  = lat_wdata;
    dm_we   = (state == ACCESS) & lat_we;
    busy    = (state != IDLE);
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (dm_4k: word-addressed, combinational read, clocked write) between two requesters.
- Port 0 is the CPU datapath load/store path. Port 1 is the debug/program-loader port.
- Each access is sequenced through a small FSM: arbitrate, access, respond.
- Ties go to the CPU, with a bounded-starvation guarantee for the debug port.

Parameters:
- ADDR_W, 10, word-address width into data memory.
- DATA_W, 32, data width.
- CPU_WEIGHT, 3, maximum consecutive CPU grants while the debug port is pending before debug is forced. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ack is high.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same meaning for the debug port.
- dbg_ack  out  1  one-cycle completion pulse to the debug port.
- dbg_rdata  out  DATA_W  debug read data; valid while dbg_ack is high.
- dm_addr  out  ADDR_W  memory address.
- dm_din  out  DATA_W  memory write data.
- dm_we  out  1  memory write enable.
- dm_dout  in  DATA_W  memory read data, combinational from dm_addr.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, owner=0, streak=0.
  - Latched addr/wdata/we = 0; cpu_rdata = dbg_rdata = 0.
  - cpu_ack = dbg_ack = dm_we = busy = 0.
  - A reset mid-access aborts it with no ack and no write. If reset asserts during ACCESS, dm_we drops immediately; the write is not committed unless a clock edge occurred first.
- States: IDLE -> ACCESS -> RESP -> IDLE. No other transitions. No re-arbitration from RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise choose a winner, latch the winner's we/addr/wdata, set owner, and go to ACCESS.
- Arbitration rules:
  - Only cpu_req high: CPU wins.
  - Only dbg_req high: debug wins.
  - Both high: CPU wins if streak < CPU_WEIGHT, else debug wins.
- Streak counter (4 bits):
  - CPU grant with dbg_req high: streak+1, saturating at 15.
  - CPU grant with dbg_req low: streak=0.
  - Debug grant: streak=0.
- ACCESS (exactly one cycle):
  - dm_addr and dm_din come from the latched values; dm_we = latched we.
  - Write commits at the edge leaving ACCESS.
  - On a read, the owner's rdata register captures dm_dout at that edge; the other port's rdata holds.
  - On a write, rdata holds its previous value.
- RESP (one cycle):
  - The owner's ack is 1 and the other ack is 0; dm_we=0.
  - Next state is IDLE.
- Outside ACCESS: dm_we=0; dm_addr and dm_din hold the latched values.
- Latency: request sampled at edge N; memory cycle is N+1; ack is high during cycle N+2. Throughput is one access per 3 cycles.
- Requester obligations:
  - Inputs must stay stable until ack.
  - The requester must drop req in the cycle after ack, or keep it high to issue a new request that will be sampled in IDLE.
  - Input changes after the grant edge do not affect the access in flight.
- A req that drops before it is granted is simply not served; no error is raised.
- busy = (state != IDLE).

Test Plan:
- CPU write then read:
  - Stimulus: cpu write addr=0x005 data=0xDEADBEEF, then cpu read addr=0x005.
  - Response: dm_we high for exactly one cycle with dm_addr=0x005; cpu_ack 2 cycles after the sampling edge; read returns cpu_rdata=0xDEADBEEF with cpu_ack; dbg_ack stays 0.
- Tie with CPU_WEIGHT=3:
  - Stimulus: cpu_req and dbg_req both held high continuously.
  - Response: grant sequence CPU, CPU, CPU, DBG, CPU, CPU, CPU, DBG; each ack spaced 3 cycles apart.
- Debug alone:
  - Stimulus: dbg read addr=0x3FF containing 0x12345678.
  - Response: dbg_rdata=0x12345678 with dbg_ack; cpu_rdata unchanged from prior value 0xDEADBEEF.
- Streak reset:
  - Stimulus: 2 CPU grants with dbg pending, then one CPU grant with dbg_req low, then both high.
  - Response: CPU wins 3 more ties before debug (streak was cleared).
- Mid-access reset:
  - Stimulus: assert rst during ACCESS of a cpu write addr=0x010 data=0x1, asynchronously before the edge.
  - Response: dm_we falls immediately; mem[0x010] is unchanged; no ack; busy=0; after rst release the FSM is in IDLE with all outputs 0.
- Input change after grant:
  - Stimulus: change cpu_addr from 0x020 to 0x021 in the ACCESS cycle.
  - Response: the access still targets 0x020.
